// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Word addresses split as {tag, index, word offset}; lines are four 32-bit words.
package dcache_pkg;

    localparam int ADDR_W     = 30;
    localparam int TAG_W      = 25;
    localparam int IDX_W      = 3;
    localparam int OFF_W      = 2;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = 128;
    localparam int MEM_ADDR_W = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] off;
    } addr_t;

    // Word i of a line lives at bits [32i+31:32i].
    function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFF_W-1:0]  off);
        return line[{off, 5'b0} +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the cache with asynchronous read,
// a single-word write port (marks line dirty) and a whole-line fill port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [IDX_W-1:0]                   idx,
    output logic [TAG_W-1:0]                   rd_tag,
    output logic                               rd_valid,
    output logic                               rd_dirty,
    output logic [WORDS_PER_LINE*WORD_W-1:0]   rd_line,
    input  logic                               word_we,
    input  logic [OFF_W-1:0]                   word_off,
    input  logic [WORD_W-1:0]                  word_data,
    input  logic                               line_we,
    input  logic [TAG_W-1:0]                   line_tag,
    input  logic [WORDS_PER_LINE*WORD_W-1:0]   line_data
);

    localparam int DATA_W = WORDS_PER_LINE * WORD_W;

    logic [TAG_W-1:0]  tag_all   [NUM_LINES];
    logic              valid_all [NUM_LINES];
    logic              dirty_all [NUM_LINES];
    logic [DATA_W-1:0] data_all  [NUM_LINES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
            logic [TAG_W-1:0]  tag_reg;
            logic              valid_reg;
            logic              dirty_reg;
            logic [DATA_W-1:0] data_reg;
            logic              line_sel;

            assign line_sel = (idx == IDX_W'(gi));

            // A fill takes priority; the controller never asserts both ports at once.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_reg   <= '0;
                    valid_reg <= 1'b0;
                    dirty_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (line_sel && line_we) begin
                    tag_reg   <= line_tag;
                    valid_reg <= 1'b1;
                    dirty_reg <= 1'b0;
                    data_reg  <= line_data;
                end else if (line_sel && word_we) begin
                    dirty_reg <= 1'b1;
                    data_reg[{word_off, 5'b0} +: WORD_W] <= word_data;
                end
            end

            assign tag_all[gi]   = tag_reg;
            assign valid_all[gi] = valid_reg;
            assign dirty_all[gi] = dirty_reg;
            assign data_all[gi]  = data_reg;
        end
    endgenerate

    assign rd_tag   = tag_all[idx];
    assign rd_valid = valid_all[idx];
    assign rd_dirty = dirty_all[idx];
    assign rd_line  = data_all[idx];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with zero-wait hits.
// Misses stall the processor while the FSM writes back a dirty victim and fills.
module dcache
    import dcache_pkg::*;
#(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  proc_read,
    input  logic                  proc_write,
    input  logic [ADDR_W-1:0]     proc_addr,
    input  logic [WORD_W-1:0]     proc_wdata,
    output logic                  proc_stall,
    output logic [WORD_W-1:0]     proc_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]     mem_wdata,
    input  logic [LINE_W-1:0]     mem_rdata,
    input  logic                  mem_ready
);

    state_t state_reg, state_next;

    addr_t              req_addr;
    logic               req_active;
    logic               hit;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_valid;
    logic               rd_dirty;
    logic [LINE_W-1:0]  rd_line;
    logic               word_we;
    logic               line_we;

    assign req_addr   = proc_addr;
    assign req_active = proc_read | proc_write;
    assign hit        = req_active && rd_valid && (rd_tag == req_addr.tag);

    dcache_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .idx       (req_addr.idx),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_line   (rd_line),
        .word_we   (word_we),
        .word_off  (req_addr.off),
        .word_data (proc_wdata),
        .line_we   (line_we),
        .line_tag  (req_addr.tag),
        .line_data (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A simultaneous read and write is handled as a write.
    always_comb begin
        state_next = state_reg;
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        word_we    = 1'b0;
        line_we    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_active) begin
                    if (hit) begin
                        word_we = proc_write;
                    end else begin
                        proc_stall = 1'b1;
                        state_next = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {rd_tag, req_addr.idx};
                mem_wdata  = rd_line;
                if (mem_ready) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[ADDR_W-1:OFF_W];
                if (mem_ready) begin
                    line_we    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign proc_rdata = rst ? '0 : get_word(rd_line, req_addr.off);

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: a backing-memory responder plus a flat
// reference memory feed a read-data scoreboard; per-scenario tasks check timing.
module tb_dcache;

    logic          clk = 1'b0;
    logic          rst;
    logic          proc_read;
    logic          proc_write;
    logic [29:0]   proc_addr;
    logic [31:0]   proc_wdata;
    logic          proc_stall;
    logic [31:0]   proc_rdata;
    logic          mem_read;
    logic          mem_write;
    logic [27:0]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_ready;

    always #5 clk = ~clk;

    dcache #(
        .NUM_LINES      (8),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    logic [127:0] mem_lines [logic [27:0]];
    logic [31:0]  ref_wr    [logic [29:0]];
    logic [31:0]  exp_q     [$];
    int vectors    = 0;
    int miscompares = 0;

    int           last_stall;
    bit           last_wb_seen;
    logic [27:0]  last_wb_addr;
    logic [127:0] last_wb_data;
    bit           last_rd_seen;
    logic [27:0]  last_rd_addr;

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return 32'h5A000000 ^ {2'b00, wa};
    endfunction

    function automatic logic [127:0] get_line(input logic [27:0] la);
        logic [127:0] l;
        if (mem_lines.exists(la)) return mem_lines[la];
        for (int i = 0; i < 4; i++) l[32*i +: 32] = init_word({la, 2'(i)});
        return l;
    endfunction

    function automatic logic [31:0] ref_read(input logic [29:0] wa);
        logic [127:0] l;
        if (ref_wr.exists(wa)) return ref_wr[wa];
        l = get_line(wa[29:2]);
        return l[32*wa[1:0] +: 32];
    endfunction

    // One processor transaction; the task also plays the memory with fixed latency.
    task automatic access(input bit rd, input bit wr, input logic [29:0] addr,
                          input logic [31:0] wd, input int lat, input string name);
        int cnt;
        int cycles;
        bit done;
        logic [31:0] exp;
        last_stall   = 0;
        last_wb_seen = 0;
        last_rd_seen = 0;
        last_wb_addr = '0;
        last_wb_data = '0;
        last_rd_addr = '0;
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = addr;
        proc_wdata = wd;
        if (rd && !wr) exp_q.push_back(ref_read(addr));
        cnt = 0;
        cycles = 0;
        done = 0;
        while (!done && cycles < 300) begin
            mem_ready = 1'b0;
            #1;
            vectors++;
            if (mem_read === 1'b1 && mem_write === 1'b1) begin
                miscompares++;
                $display("FAIL %s overlap: mem_read=%b mem_write=%b, required not both high", name, mem_read, mem_write);
            end
            if (proc_stall === 1'b0) begin
                done = 1;
                vectors++;
                if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 28'h0 || mem_wdata !== 128'h0) begin
                    miscompares++;
                    $display("FAIL %s idle_mem: rd=%b wr=%b addr=%h wdata=%h, required all 0", name, mem_read, mem_write, mem_addr, mem_wdata);
                end
                if (rd && !wr) begin
                    exp = exp_q.pop_front();
                    vectors++;
                    if (proc_rdata !== exp) begin
                        miscompares++;
                        $display("FAIL %s rdata: got %h, required %h", name, proc_rdata, exp);
                    end
                end else begin
                    ref_wr[addr] = wd;
                end
            end else begin
                last_stall++;
                if (mem_write === 1'b1) begin
                    if (!last_wb_seen) begin
                        last_wb_seen = 1;
                        last_wb_addr = mem_addr;
                        last_wb_data = mem_wdata;
                    end
                    cnt++;
                    if (cnt >= lat) begin
                        mem_ready = 1'b1;
                        mem_lines[mem_addr] = mem_wdata;
                        cnt = 0;
                    end
                end else if (mem_read === 1'b1) begin
                    if (!last_rd_seen) begin
                        last_rd_seen = 1;
                        last_rd_addr = mem_addr;
                    end
                    mem_rdata = get_line(mem_addr);
                    cnt++;
                    if (cnt >= lat) begin
                        mem_ready = 1'b1;
                        cnt = 0;
                    end
                end
            end
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        proc_read  = 1'b0;
        proc_write = 1'b0;
        mem_ready  = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: stall still %b after %0d cycles, required completion", name, proc_stall, cycles);
            if (rd && !wr && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        $display("txn %-10s rd=%0b wr=%0b addr=%h wdata=%h stall_cycles=%0d wb=%0b fill=%0b",
                 name, rd, wr, addr, wd, last_stall, last_wb_seen, last_rd_seen);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (proc_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall_noreq: got %b, required 0", proc_stall);
        end
        vectors++;
        if ({mem_read, mem_write, mem_addr, mem_wdata} !== 158'h0) begin
            miscompares++;
            $display("FAIL reset_mem_outputs: rd=%b wr=%b addr=%h wdata=%h, required all 0", mem_read, mem_write, mem_addr, mem_wdata);
        end
        proc_read = 1'b1;
        proc_addr = 30'h10;
        #1;
        vectors++;
        if (proc_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_stall_req: got %b, required 1", proc_stall);
        end
        vectors++;
        if (proc_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h, required 0", proc_rdata);
        end
        proc_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (proc_stall !== 1'b0 || mem_read !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: stall=%b mem_read=%b, required 0 0", proc_stall, mem_read);
        end
        @(negedge clk);
    endtask

    task automatic test_read_miss();
        access(1, 0, 30'h10, 32'h0, 3, "rd_miss");
        vectors++;
        if (!(last_rd_seen && last_rd_addr === 28'h4)) begin
            miscompares++;
            $display("FAIL fill_addr: got seen=%0b addr=%h, required seen=1 addr=0000004", last_rd_seen, last_rd_addr);
        end
        vectors++;
        if (last_stall != 4 || last_wb_seen) begin
            miscompares++;
            $display("FAIL rd_miss_stall: got %0d cycles wb=%0b, required 4 cycles wb=0", last_stall, last_wb_seen);
        end
    endtask

    task automatic test_write_hit();
        access(0, 1, 30'h10, 32'hDEADBEEF, 3, "wr_hit");
        vectors++;
        if (last_stall != 0 || last_rd_seen || last_wb_seen) begin
            miscompares++;
            $display("FAIL wr_hit: got stall=%0d fill=%0b wb=%0b, required 0 0 0", last_stall, last_rd_seen, last_wb_seen);
        end
        access(1, 0, 30'h10, 32'h0, 3, "rd_hit");
        vectors++;
        if (last_stall != 0) begin
            miscompares++;
            $display("FAIL rd_hit_stall: got %0d, required 0", last_stall);
        end
    endtask

    task automatic test_writeback();
        access(1, 0, 30'h110, 32'h0, 2, "rd_evict");
        vectors++;
        if (!last_wb_seen || last_wb_addr !== 28'h4 || last_wb_data[31:0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL wb_line: got seen=%0b addr=%h word0=%h, required 1 0000004 deadbeef", last_wb_seen, last_wb_addr, last_wb_data[31:0]);
        end
        vectors++;
        if (!last_rd_seen || last_rd_addr !== 28'h44) begin
            miscompares++;
            $display("FAIL wb_fill_addr: got seen=%0b addr=%h, required 1 0000044", last_rd_seen, last_rd_addr);
        end
        vectors++;
        if (last_stall != 5) begin
            miscompares++;
            $display("FAIL wb_stall: got %0d, required 5", last_stall);
        end
        access(1, 0, 30'h110, 32'h0, 2, "rd_hit2");
        vectors++;
        if (last_stall != 0) begin
            miscompares++;
            $display("FAIL after_fill_hit: got %0d, required 0", last_stall);
        end
        access(1, 0, 30'h10, 32'h0, 2, "rd_back");
    endtask

    task automatic test_latency();
        access(1, 0, 30'h1C, 32'h0, 5, "lat5");
        vectors++;
        if (last_stall != 6 || last_wb_seen) begin
            miscompares++;
            $display("FAIL lat5_stall: got %0d wb=%0b, required 6 wb=0", last_stall, last_wb_seen);
        end
    endtask

    task automatic test_write_miss();
        access(0, 1, 30'h208, 32'h0BADF00D, 2, "wr_miss");
        vectors++;
        if (last_stall != 3 || !last_rd_seen) begin
            miscompares++;
            $display("FAIL wr_miss_stall: got %0d fill=%0b, required 3 fill=1", last_stall, last_rd_seen);
        end
        access(1, 0, 30'h208, 32'h0, 2, "rd_wmiss");
        access(1, 0, 30'h20B, 32'h0, 2, "rd_neigh");
    endtask

    task automatic test_read_write_both();
        access(1, 1, 30'h209, 32'hCAFEF00D, 1, "rw_both");
        vectors++;
        if (last_stall != 0) begin
            miscompares++;
            $display("FAIL rw_both_stall: got %0d, required 0", last_stall);
        end
        access(1, 0, 30'h209, 32'h0, 1, "rd_rw");
    endtask

    task automatic test_ignore_ready_idle();
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b1;
            #1;
            vectors++;
            if (proc_stall !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_ready: stall=%b rd=%b wr=%b, required 0 0 0", proc_stall, mem_read, mem_write);
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        access(1, 0, 30'h10, 32'h0, 2, "rd_still");
        vectors++;
        if (last_stall != 0) begin
            miscompares++;
            $display("FAIL idle_ready_state: got stall %0d, required 0", last_stall);
        end
    endtask

    task automatic test_reset_abort();
        int waited;
        waited = 0;
        proc_read = 1'b1;
        proc_addr = 30'hA4;
        #1;
        while (mem_read !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        vectors++;
        if (mem_read !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_fill_start: got mem_read=%b, required 1", mem_read);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (mem_read !== 1'b0 || mem_addr !== 28'h0 || proc_stall !== 1'b1 || proc_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_outputs: rd=%b addr=%h stall=%b rdata=%h, required 0 0 1 0", mem_read, mem_addr, proc_stall, proc_rdata);
        end
        proc_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = {4{32'hBAD0BAD0}};
        #1;
        vectors++;
        if (mem_read !== 1'b0 || proc_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_late_ready: rd=%b stall=%b, required 0 0", mem_read, proc_stall);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        ref_wr.delete();
        access(1, 0, 30'hA4, 32'h0, 2, "rd_again");
        vectors++;
        if (!last_rd_seen || last_stall != 3) begin
            miscompares++;
            $display("FAIL abort_remiss: got fill=%0b stall=%0d, required 1 3", last_rd_seen, last_stall);
        end
    endtask

    task automatic test_back_to_back();
        logic [29:0] a;
        bit w;
        for (int i = 0; i < 24; i++) begin
            a = {25'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            w = 1'($urandom_range(0, 1));
            access(!w, w, a, $urandom, $urandom_range(1, 4), "b2b");
        end
    endtask

    initial begin
        rst        = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        mem_lines[28'h4] = {init_word(30'h13), init_word(30'h12), init_word(30'h11), 32'h11111111};

        test_reset();
        test_read_miss();
        test_write_hit();
        test_writeback();
        test_latency();
        test_write_miss();
        test_read_write_both();
        test_ignore_ready_idle();
        test_reset_abort();
        test_back_to_back();

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 The block SHALL have parameter NUM_LINES, default 8, number of direct-mapped cache lines.
REQ-002 The block SHALL have parameter WORDS_PER_LINE, default 4, 32-bit words per line (line = 128 bits).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 proc_read  input  1  processor read request, held stable while proc_stall=1.
REQ-007 proc_write  input  1  processor write request, held stable while proc_stall=1.
REQ-008 proc_addr  input  30  word address: [29:5] tag, [4:2] index, [1:0] word offset.
REQ-009 proc_wdata  input  32  store data, stored without byte reordering.
REQ-010 proc_stall  output  1  request not complete; processor holds request and pipeline.
REQ-011 proc_rdata  output  32  read data, valid when proc_read=1 and proc_stall=0.
REQ-012 mem_read  output  1  line fill request to memory.
REQ-013 mem_write  output  1  line writeback request to memory.
REQ-014 mem_addr  output  28  line address {tag,index}.
REQ-015 mem_wdata  output  128  writeback line; word i at bits [32i+31:32i].
REQ-016 mem_rdata  input  128  fill line, same word layout.
REQ-017 mem_ready  input  1  one-cycle pulse: current mem_read/mem_write transaction complete.

Function
REQ-018 The cache SHALL be direct-mapped, write-back, write-allocate, with per-line valid, dirty, 25-bit tag and 128-bit data.
REQ-019 FSM states SHALL be IDLE, WRITEBACK and ALLOCATE.
REQ-020 Hit = request active and indexed line valid and tag equal; the hit SHALL be decided combinationally in IDLE with proc_stall=0 in the same cycle (zero-wait hit).
REQ-021 A read hit SHALL drive proc_rdata from the selected word combinationally.
REQ-022 A write hit SHALL update the selected word and set dirty at the next rising edge.
REQ-023 A miss with the victim invalid or clean SHALL raise proc_stall combinationally and go IDLE->ALLOCATE.
REQ-024 A miss with the victim valid and dirty SHALL raise proc_stall and go IDLE->WRITEBACK.
REQ-025 WRITEBACK SHALL drive mem_write=1, mem_addr={stored tag,index}, mem_wdata=victim line, held until mem_ready=1; it then SHALL go to ALLOCATE.
REQ-026 ALLOCATE SHALL drive mem_read=1, mem_addr=proc_addr[29:2], held until mem_ready=1; on that edge it SHALL write mem_rdata into the line, set valid=1, dirty=0, load tag, and go to IDLE.
REQ-027 After a fill, the request SHALL be re-evaluated in IDLE as a hit on the following cycle. A write miss therefore completes there, setting dirty.
REQ-028 proc_stall SHALL be 1 throughout WRITEBACK and ALLOCATE.
REQ-029 mem_read and mem_write SHALL never be high together; both SHALL be 0 in IDLE.
REQ-030 In IDLE, mem_addr SHALL be 0 and mem_wdata SHALL be 0.
REQ-031 mem_ready in IDLE SHALL be ignored.
REQ-032 With no request, proc_stall SHALL be 0 and no state SHALL change.
REQ-033 proc_read and proc_write both high SHALL be treated as a write.
REQ-034 Clean-miss stall SHALL be exactly (cycles until mem_ready) + 1.

Reset
REQ-035 Asserting rst SHALL immediately force state IDLE, clear all valid and dirty bits, clear tags and data to 0, and drive mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-036 A reset mid-WRITEBACK or mid-ALLOCATE SHALL abort the transaction with no line update, and a mem_ready arriving after reset SHALL be ignored.
REQ-037 With rst asserted, proc_rdata SHALL be 0 and proc_stall SHALL reflect a miss only if a request is present.

Structure
REQ-038 Shared package dcache_pkg SHALL hold the state enum, TAG_W=25, IDX_W=3, OFF_W=2 and LINE_W=128.
REQ-039 Storage (tag, valid, dirty, data arrays with word-write and line-write ports) SHALL be sub-module dcache_array; the FSM and hit logic SHALL live in dcache.

Verification
REQ-040 After reset: read 0x0000010 -> proc_stall=1, mem_read=1, mem_addr=0x0000004; mem_ready with word0=0x11111111 -> next cycle proc_stall=0, proc_rdata=0x11111111.
REQ-041 Write 0xDEADBEEF to the same address -> proc_stall=0 that cycle, no mem activity; a later read returns 0xDEADBEEF.
REQ-042 Read at proc_addr=0x0000110 (same index, different tag) -> mem_write=1, mem_addr=0x0000004, mem_wdata word0=0xDEADBEEF. Then mem_read with mem_addr=0x0000044, then a hit.
REQ-043 Memory latency 5 cycles on a clean miss -> proc_stall high for exactly 6 cycles; mem_read never overlaps mem_write.
REQ-044 rst pulsed during ALLOCATE -> mem_read drops immediately; a subsequent read to the same address misses again.
